// File: rtl/uart_frame_streamer_v2.sv
// ROI-decimating pixel streamer: header, RGB565/GRAY8 pixels, trailer over 8N1.
// Ports: clk, rst_n, frame_valid, pixel_valid, pixel_x/y/data in; tx, busy, overflow, frame_count, led_activity out.

module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CL = CLKS_PER_BIT - 1;
  localparam logic [CW-1:0] CLK_LAST = CL[CW-1:0];

  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift;

  // shift holds data bits then the stop bit; tx is driven from a register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= 1'b1;
      busy    <= 1'b0;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '1;
    end else if (!busy) begin
      if (start) begin
        tx      <= 1'b0;
        busy    <= 1'b1;
        clk_cnt <= '0;
        bit_cnt <= '0;
        shift   <= {1'b1, data};
      end
    end else if (clk_cnt != CLK_LAST) begin
      clk_cnt <= clk_cnt + 1'b1;
    end else begin
      clk_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        busy <= 1'b0;
        tx   <= 1'b1;
      end else begin
        tx      <= shift[0];
        shift   <= {1'b1, shift[8:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end
endmodule

module uart_frame_streamer_v2 #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int H_SCALE    = 8,
  parameter int V_SCALE    = 8,
  parameter int ROI_X0     = 280,
  parameter int ROI_Y0     = 210,
  parameter int ROI_W      = 80,
  parameter int ROI_H      = 60,
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_MODE   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  input  logic        pixel_valid,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [15:0] pixel_data,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  frame_count,
  output logic        led_activity
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int XE  = ROI_X0 + ROI_W;
  localparam int YE  = ROI_Y0 + ROI_H;
  localparam int WO  = ROI_W / H_SCALE;
  localparam int HO  = ROI_H / V_SCALE;
  localparam int HM  = H_SCALE - 1;
  localparam int VM  = V_SCALE - 1;
  localparam bit GRAY_MODE = PIX_MODE != 0;
  localparam logic [AW:0]  FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [10:0]  X_LO = ROI_X0[10:0];
  localparam logic [10:0]  X_HI = XE[10:0];
  localparam logic [10:0]  Y_LO = ROI_Y0[10:0];
  localparam logic [10:0]  Y_HI = YE[10:0];
  localparam logic [15:0]  W_OUT = WO[15:0];
  localparam logic [15:0]  H_OUT = HO[15:0];
  localparam logic [9:0]   H_MASK = HM[9:0];
  localparam logic [9:0]   V_MASK = VM[9:0];
  localparam logic [7:0]   BPP = GRAY_MODE ? 8'd8 : 8'd16;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PIX_HI, S_PIX_LO, S_TRL
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  idx, idx_nx;
  logic        fv_q, frame_active, accept, fv_fall;
  logic        tx_start, uart_busy, can, issue, pop, pix_byte;
  logic [7:0]  tx_byte, byte_nx, frame_byte, checksum, lo_q;
  logic [2:0]  led_cnt;
  logic        on_grid, in_roi, push_req, push_ok, empty, full;
  logic [15:0] mem [FIFO_DEPTH];
  logic [15:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]  r8, g8, b8, gray;
  logic [9:0]  gsum;
  logic        unused_gsum;

  assign accept  = (state == S_IDLE) && frame_valid && !fv_q;
  assign fv_fall = !frame_valid && fv_q;
  assign busy    = state != S_IDLE;
  // one-cycle start pulse, never back to back
  assign can     = !uart_busy && !tx_start;

  assign on_grid = ((pixel_x & H_MASK) == 10'd0) && ((pixel_y & V_MASK) == 10'd0);
  assign in_roi  = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI) &&
                   ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);
  assign push_req = pixel_valid && frame_active && on_grid && in_roi && (state != S_IDLE);
  assign push_ok  = push_req && !full;

  assign empty = count == '0;
  assign full  = count == FULL_CNT;
  assign head  = mem[rd_ptr];

  assign r8   = {head[15:11], head[15:13]};
  assign g8   = {head[10:5], head[10:9]};
  assign b8   = {head[4:0], head[4:2]};
  assign gsum = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
  assign gray = gsum[9:2];
  assign unused_gsum = ^gsum[1:0];

  always_comb begin
    frame_byte = 8'h5A;
    if (state == S_TRL) begin
      unique case (idx)
        3'd0:    frame_byte = checksum;
        3'd1:    frame_byte = {7'b0, overflow};
        default: frame_byte = 8'hC3;
      endcase
    end else begin
      unique case (idx)
        3'd0:    frame_byte = 8'hA5;
        3'd1:    frame_byte = frame_count;
        3'd2:    frame_byte = W_OUT[7:0];
        3'd3:    frame_byte = W_OUT[15:8];
        3'd4:    frame_byte = H_OUT[7:0];
        3'd5:    frame_byte = H_OUT[15:8];
        3'd6:    frame_byte = BPP;
        default: frame_byte = 8'h5A;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    issue    = 1'b0;
    pop      = 1'b0;
    pix_byte = 1'b0;
    byte_nx  = frame_byte;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_HDR;
          idx_nx   = 3'd0;
        end
      end
      S_HDR: begin
        issue = can;
        if (can) begin
          idx_nx = idx + 3'd1;
          if (idx == 3'd7) state_nx = S_PIX_HI;
        end
      end
      S_PIX_HI: begin
        if (!empty) begin
          issue    = can;
          pop      = can;
          pix_byte = 1'b1;
          byte_nx  = GRAY_MODE ? gray : head[15:8];
          if (can && !GRAY_MODE) state_nx = S_PIX_LO;
        end else if (!frame_active) begin
          state_nx = S_TRL;
          idx_nx   = 3'd0;
        end
      end
      S_PIX_LO: begin
        issue    = can;
        pix_byte = 1'b1;
        byte_nx  = lo_q;
        if (can) state_nx = S_PIX_HI;
      end
      S_TRL: begin
        issue = can;
        if (can) begin
          idx_nx = idx + 3'd1;
          if (idx == 3'd2) state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      fv_q         <= 1'b0;
      frame_active <= 1'b0;
      tx_start     <= 1'b0;
      tx_byte      <= 8'h00;
      lo_q         <= 8'h00;
      checksum     <= 8'h00;
      overflow     <= 1'b0;
      frame_count  <= 8'h00;
      led_cnt      <= '0;
      led_activity <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      fv_q     <= frame_valid;
      tx_start <= issue;
      if (issue) tx_byte <= byte_nx;
      if (pop) lo_q <= head[7:0];
      if (accept) frame_active <= 1'b1;
      else if (fv_fall) frame_active <= 1'b0;
      if (accept) checksum <= 8'h00;
      else if (issue && pix_byte) checksum <= checksum ^ byte_nx;
      if (accept) overflow <= 1'b0;
      else if (push_req && full) overflow <= 1'b1;
      if (issue) begin
        led_cnt <= led_cnt + 3'd1;
        if (led_cnt == 3'd7) led_activity <= !led_activity;
      end
      if (issue && state == S_TRL && idx == 3'd2) frame_count <= frame_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (accept) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop) count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= pixel_data;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_uart (
    .clk  (clk),
    .rst_n(rst_n),
    .start(tx_start),
    .data (tx_byte),
    .tx   (tx),
    .busy (uart_busy)
  );
endmodule

// File: tb/tb_uart_frame_streamer_v2.sv
// Bench: two streamers (RGB565 and GRAY8, different ROIs) fed the same pixels.
// Expected bytes come from a frame-level model; UART decoders pop and compare.

module tb_uart_frame_streamer_v2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic frame_valid = 1'b0;
  logic pixel_valid = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic [15:0] pixel_data = '0;
  logic tx0, tx1, busy0, busy1, ovf0, ovf1, led0, led1;
  logic [7:0] fc0, fc1;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  localparam int DEPTH = 4;
  int rx0 [2] = '{0, 8};
  int ry0 [2] = '{0, 16};
  int rw  [2] = '{16, 16};
  int rh  [2] = '{16, 8};
  int mode[2] = '{0, 1};
  int fcm [2] = '{0, 0};
  int nb  [2] = '{0, 0};
  bit exp_ovf[2] = '{1'b0, 1'b0};

  int sx[$];
  int sy[$];
  logic [15:0] sd[$];
  logic [7:0] eq0[$];
  logic [7:0] eq1[$];

  always #5 clk = ~clk;

  uart_frame_streamer_v2 #(
    .CLK_FREQ(1000), .BAUD(100), .H_SCALE(8), .V_SCALE(8),
    .ROI_X0(0), .ROI_Y0(0), .ROI_W(16), .ROI_H(16),
    .FIFO_DEPTH(DEPTH), .PIX_MODE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_data(pixel_data), .tx(tx0), .busy(busy0), .overflow(ovf0),
    .frame_count(fc0), .led_activity(led0)
  );

  uart_frame_streamer_v2 #(
    .CLK_FREQ(1000), .BAUD(100), .H_SCALE(8), .V_SCALE(8),
    .ROI_X0(8), .ROI_Y0(16), .ROI_W(16), .ROI_H(8),
    .FIFO_DEPTH(DEPTH), .PIX_MODE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_data(pixel_data), .tx(tx1), .busy(busy1), .overflow(ovf1),
    .frame_count(fc1), .led_activity(led1)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  function automatic bit selected(input int k, input int x, input int y);
    return (x % 8 == 0) && (y % 8 == 0) &&
           x >= rx0[k] && x < rx0[k] + rw[k] &&
           y >= ry0[k] && y < ry0[k] + rh[k];
  endfunction

  function automatic logic [7:0] gray_of(input logic [15:0] d);
    int r, g, b;
    r = int'(d[15:11]);
    g = int'(d[10:5]);
    b = int'(d[4:0]);
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    return 8'((r + 2 * g + b) / 4);
  endfunction

  task automatic push(input int k, input logic [7:0] b);
    if (k == 0) eq0.push_back(b);
    else eq1.push_back(b);
    nb[k]++;
  endtask

  // pixels arrive during the header, so the first DEPTH selected fit and the rest drop
  task automatic expect_frame(input int k);
    int kept;
    bit ovf;
    logic [7:0] ck, g;
    logic [15:0] d;
    kept = 0;
    ovf = 1'b0;
    ck = 8'h00;
    push(k, 8'hA5);
    push(k, 8'(fcm[k]));
    push(k, 8'(rw[k] / 8));
    push(k, 8'((rw[k] / 8) >> 8));
    push(k, 8'(rh[k] / 8));
    push(k, 8'((rh[k] / 8) >> 8));
    push(k, mode[k] != 0 ? 8'd8 : 8'd16);
    push(k, 8'h5A);
    for (int i = 0; i < sx.size(); i++) begin
      if (selected(k, sx[i], sy[i])) begin
        if (kept < DEPTH) begin
          kept++;
          d = sd[i];
          if (mode[k] != 0) begin
            g = gray_of(d);
            push(k, g);
            ck ^= g;
          end else begin
            push(k, d[15:8]);
            push(k, d[7:0]);
            ck ^= d[15:8] ^ d[7:0];
          end
        end else begin
          ovf = 1'b1;
        end
      end
    end
    push(k, ck);
    push(k, {7'b0, ovf});
    push(k, 8'hC3);
    exp_ovf[k] = ovf;
    fcm[k]++;
  endtask

  task automatic mon(input int k);
    logic [7:0] v, e;
    logic stop;
    forever begin
      @(negedge clk);
      if ((k == 0 ? tx0 : tx1) == 1'b0) begin
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          v[i] = k == 0 ? tx0 : tx1;
        end
        repeat (10) @(negedge clk);
        stop = k == 0 ? tx0 : tx1;
        if (mon_en) begin
          chk($sformatf("stop_bit%0d", k), 32'(stop), 32'd1);
          checks++;
          if ((k == 0 ? eq0.size() : eq1.size()) == 0) begin
            errors++;
            $display("FAIL unexpected_byte%0d got=%0h want=none", k, v);
          end else begin
            if (k == 0) e = eq0.pop_front();
            else e = eq1.pop_front();
            if (v !== e) begin
              errors++;
              $display("FAIL byte%0d got=%0h want=%0h", k, v, e);
            end
          end
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic run_frame(input bit ignored_rise);
    int t;
    expect_frame(0);
    expect_frame(1);
    @(negedge clk);
    frame_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < sx.size(); i++) begin
      pixel_valid = 1'b1;
      pixel_x = 10'(sx[i]);
      pixel_y = 10'(sy[i]);
      pixel_data = sd[i];
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    repeat (3) @(negedge clk);
    frame_valid = 1'b0;
    if (ignored_rise) begin
      repeat (100) @(negedge clk);
      frame_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
        pixel_valid = 1'b1;
        pixel_x = (i % 2 == 0) ? 10'd0 : 10'd8;
        pixel_y = (i % 2 == 0) ? 10'd0 : 10'd16;
        pixel_data = 16'($urandom);
        @(negedge clk);
      end
      pixel_valid = 1'b0;
      repeat (4) @(negedge clk);
      frame_valid = 1'b0;
    end
    t = 0;
    while ((busy0 || busy1) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 20000) begin
      errors++;
      $display("FAIL frame_timeout got=busy want=idle");
    end
    chk("frame_count0", 32'(fc0), 32'(8'(fcm[0])));
    chk("frame_count1", 32'(fc1), 32'(8'(fcm[1])));
    chk("overflow0", 32'(ovf0), 32'(exp_ovf[0]));
    chk("overflow1", 32'(ovf1), 32'(exp_ovf[1]));
    chk("led0", 32'(led0), 32'((nb[0] / 8) % 2));
    chk("led1", 32'(led1), 32'((nb[1] / 8) % 2));
  endtask

  task automatic clear_stim();
    sx.delete();
    sy.delete();
    sd.delete();
  endtask

  task automatic add_px(input int x, input int y, input logic [15:0] d);
    sx.push_back(x);
    sy.push_back(y);
    sd.push_back(d);
  endtask

  initial begin
    int t, n, x, y;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx0", 32'(tx0), 32'd1);
    chk("rst_tx1", 32'(tx1), 32'd1);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_ovf0", 32'(ovf0), 32'd0);
    chk("rst_fc0", 32'(fc0), 32'd0);
    chk("rst_led0", 32'(led0), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    clear_stim();
    for (int yy = 0; yy < 17; yy++)
      for (int xx = 0; xx < 640; xx++)
        add_px(xx, yy, 16'(xx) ^ 16'(yy << 6));
    run_frame(1'b0);

    clear_stim();
    add_px(8, 16, 16'hFFFF);
    add_px(16, 16, 16'hF800);
    add_px(8, 16, 16'h07E0);
    add_px(16, 16, 16'h001F);
    run_frame(1'b1);

    clear_stim();
    for (int i = 0; i < 10; i++)
      add_px((i % 2) * 8, ((i / 2) % 2) * 8, 16'($urandom));
    for (int i = 0; i < 6; i++)
      add_px(8 + (i % 2) * 8, 16, 16'($urandom));
    run_frame(1'b0);

    for (int f = 0; f < 6; f++) begin
      clear_stim();
      n = $urandom_range(4, 14);
      for (int i = 0; i < n; i++) begin
        x = 8 * $urandom_range(0, 3) + ($urandom_range(0, 4) == 0 ? $urandom_range(1, 7) : 0);
        y = 8 * $urandom_range(0, 3) + ($urandom_range(0, 4) == 0 ? $urandom_range(1, 7) : 0);
        add_px(x, y, 16'($urandom));
      end
      run_frame(1'($urandom_range(0, 1)));
    end

    t = 0;
    while ((eq0.size() != 0 || eq1.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drained0", 32'(eq0.size()), 32'd0);
    chk("drained1", 32'(eq1.size()), 32'd0);

    mon_en = 1'b0;
    frame_valid = 1'b1;
    repeat (27) @(negedge clk);
    chk("busy_before_rst", 32'(busy0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx0", 32'(tx0), 32'd1);
    chk("midrst_tx1", 32'(tx1), 32'd1);
    chk("midrst_busy0", 32'(busy0), 32'd0);
    chk("midrst_busy1", 32'(busy1), 32'd0);
    chk("midrst_fc0", 32'(fc0), 32'd0);
    chk("midrst_fc1", 32'(fc1), 32'd0);
    chk("midrst_ovf0", 32'(ovf0), 32'd0);
    chk("midrst_led0", 32'(led0), 32'd0);
    frame_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
